// File: rtl/ps2_defs.sv
// Shared constants and types for the PS/2 scan code decoder.
package ps2_defs;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned PS2_EVENT_W = 10;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExt    = 2'd1,
    StBrk    = 2'd2,
    StExtBrk = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO is accepted only alongside a pop.
module ps2_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_scan_code_decoder.sv
// Turns a stream of PS/2 scan bytes into prefix-free key events queued in a FIFO.
module ps2_scan_code_decoder
  import ps2_defs::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic       FCLK,
  input  logic       RST,
  input  logic [7:0] SCAN_CODE,
  input  logic       CODE_VALID,
  input  logic       PARITY_OK,
  input  logic       EVENT_READY,
  output logic       EVENT_VALID,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXTENDED,
  output logic       KEY_RELEASED,
  output logic       OVERFLOW,
  output logic [7:0] PARITY_ERR_CNT
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]  err_q, err_d;
  logic        push_q, push_d;
  ps2_event_t  entry_q, entry_d;
  logic        overflow_q, overflow_d;
  ps2_event_t  head;
  logic        full, empty;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    push_d  = 1'b0;
    entry_d = entry_q;
    if (CODE_VALID) begin
      timer_d = '0;
      if (!PARITY_OK) begin
        state_d = StIdle;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (SCAN_CODE == PS2_PREFIX_EXT)      state_d = StExt;
            else if (SCAN_CODE == PS2_PREFIX_BRK) state_d = StBrk;
            else begin
              push_d  = 1'b1;
              entry_d = '{ext: 1'b0, rel: 1'b0, code: SCAN_CODE};
            end
          end
          StExt: begin
            if (SCAN_CODE == PS2_PREFIX_BRK)      state_d = StExtBrk;
            else if (SCAN_CODE == PS2_PREFIX_EXT) state_d = StExt;
            else begin
              state_d = StIdle;
              push_d  = 1'b1;
              entry_d = '{ext: 1'b1, rel: 1'b0, code: SCAN_CODE};
            end
          end
          StBrk, StExtBrk: begin
            state_d = StIdle;
            // A prefix byte after F0 is malformed: drop the whole sequence.
            if (SCAN_CODE != PS2_PREFIX_EXT && SCAN_CODE != PS2_PREFIX_BRK) begin
              push_d  = 1'b1;
              entry_d = '{ext: (state_q == StExtBrk), rel: 1'b1, code: SCAN_CODE};
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end else if (state_q != StIdle) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = StIdle;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Push arriving on a full FIFO is lost unless the consumer pops in the same cycle.
  assign overflow_d = overflow_q | (push_q && full && !EVENT_READY);

  always_ff @(posedge FCLK) begin
    if (RST) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      err_q      <= '0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      overflow_q <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk_i   (FCLK),
    .rst_i   (RST),
    .push_i  (push_q),
    .wdata_i (entry_q),
    .pop_i   (EVENT_READY),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign EVENT_VALID    = !empty;
  assign KEY_CODE       = EVENT_VALID ? head.code : 8'h00;
  assign KEY_EXTENDED   = EVENT_VALID & head.ext;
  assign KEY_RELEASED   = EVENT_VALID & head.rel;
  assign OVERFLOW       = overflow_q;
  assign PARITY_ERR_CNT = err_q;

endmodule

// File: tb/tb_ps2_scan_code_decoder.sv
// Table vectors, directed corner sequences and random traffic against a prefix-list model.
module tb_ps2_scan_code_decoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic       FCLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] SCAN_CODE = 8'h00;
  logic       CODE_VALID = 1'b0;
  logic       PARITY_OK = 1'b1;
  logic       EVENT_READY = 1'b0;
  logic       EVENT_VALID;
  logic [7:0] KEY_CODE;
  logic       KEY_EXTENDED;
  logic       KEY_RELEASED;
  logic       OVERFLOW;
  logic [7:0] PARITY_ERR_CNT;

  int checks = 0;
  int failures = 0;

  ps2_scan_code_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .FCLK           (FCLK),
    .RST            (RST),
    .SCAN_CODE      (SCAN_CODE),
    .CODE_VALID     (CODE_VALID),
    .PARITY_OK      (PARITY_OK),
    .EVENT_READY    (EVENT_READY),
    .EVENT_VALID    (EVENT_VALID),
    .KEY_CODE       (KEY_CODE),
    .KEY_EXTENDED   (KEY_EXTENDED),
    .KEY_RELEASED   (KEY_RELEASED),
    .OVERFLOW       (OVERFLOW),
    .PARITY_ERR_CNT (PARITY_ERR_CNT)
  );

  always #5 FCLK = ~FCLK;

  // Reference model: pending prefix bytes, event queue, one-cycle write delay.
  logic [9:0] mq[$];
  logic [7:0] pre[$];
  int         idle_cnt = 0;
  bit         pend = 0;
  logic [9:0] pend_e = '0;
  bit         m_ovf = 0;
  int         m_err = 0;

  function automatic bit pre_has(input logic [7:0] b);
    foreach (pre[i]) if (pre[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit pop, was_full;
    if (RST) begin
      mq.delete(); pre.delete();
      idle_cnt = 0; pend = 0; m_ovf = 0; m_err = 0;
      return;
    end
    pop      = (mq.size() > 0) && EVENT_READY;
    was_full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (pend) begin
      if (!was_full || pop) mq.push_back(pend_e);
      else m_ovf = 1;
    end
    pend = 0;
    if (CODE_VALID) begin
      idle_cnt = 0;
      if (!PARITY_OK) begin
        pre.delete();
        if (m_err < 255) m_err++;
      end else if (SCAN_CODE == 8'hE0 || SCAN_CODE == 8'hF0) begin
        if (pre_has(8'hF0)) pre.delete();
        else pre.push_back(SCAN_CODE);
      end else begin
        pend   = 1;
        pend_e = {pre_has(8'hE0), pre_has(8'hF0), SCAN_CODE};
        pre.delete();
      end
    end else if (pre.size() != 0) begin
      idle_cnt++;
      if (idle_cnt == TMO) begin
        pre.delete();
        idle_cnt = 0;
      end
    end else begin
      idle_cnt = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'h000;
    chk("m_valid", 32'(EVENT_VALID), 32'(mq.size() > 0));
    chk("m_code", 32'(KEY_CODE), 32'(h[7:0]));
    chk("m_ext", 32'(KEY_EXTENDED), 32'(h[9]));
    chk("m_rel", 32'(KEY_RELEASED), 32'(h[8]));
    chk("m_ovf", 32'(OVERFLOW), 32'(m_ovf));
    chk("m_err", 32'(PARITY_ERR_CNT), 32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
  task automatic cycle(input logic v, input logic [7:0] c, input logic p, input logic r,
                       input logic rs);
    CODE_VALID = v; SCAN_CODE = c; PARITY_OK = p; EVENT_READY = r; RST = rs;
    @(posedge FCLK);
    model_step();
    @(negedge FCLK);
    check_model();
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, r, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic [7:0] code;
    logic       par;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_code;
    logic       e_ext;
    logic       e_rel;
    logic [7:0] e_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 8'hF0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 8'h74, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h74, 1'b1, 1'b1, 8'd0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[12] = '{1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 8'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd1};

    // Reset state
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 8'h1C, 1'b1, 1'b1, 1'b1);
    chk("rst_valid", 32'(EVENT_VALID), 0);
    chk("rst_code", 32'(KEY_CODE), 0);
    chk("rst_ovf", 32'(OVERFLOW), 0);
    chk("rst_err", 32'(PARITY_ERR_CNT), 0);
    idle(1, 1'b0);
    chk("rst_dominates", 32'(EVENT_VALID), 0);

    // Table vectors: basic make, E0 F0 break, parity reject, extended make
    for (int i = 0; i < 16; i++) begin
      cycle(vecs[i].v, vecs[i].code, vecs[i].par, vecs[i].rdy, 1'b0);
      chk($sformatf("vec%0d_valid", i), 32'(EVENT_VALID), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_code", i), 32'(KEY_CODE), 32'(vecs[i].e_code));
      chk($sformatf("vec%0d_ext", i), 32'(KEY_EXTENDED), 32'(vecs[i].e_ext));
      chk($sformatf("vec%0d_rel", i), 32'(KEY_RELEASED), 32'(vecs[i].e_rel));
      chk($sformatf("vec%0d_err", i), 32'(PARITY_ERR_CNT), 32'(vecs[i].e_err));
    end

    // Overflow: five makes into a four-deep FIFO, then drain in order
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h15 + i), 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("ovf_set", 32'(OVERFLOW), 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(KEY_CODE), 32'(8'h15 + i));
      idle(1, 1'b1);
    end
    chk("drain_empty", 32'(EVENT_VALID), 0);
    chk("ovf_sticky", 32'(OVERFLOW), 1);

    // Push and pop together while full: no overflow
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("rst_clears_ovf", 32'(OVERFLOW), 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h21 + i), 1'b1, 1'b0, 1'b0);
    idle(1, 1'b1);
    chk("fullpp_ovf", 32'(OVERFLOW), 0);
    chk("fullpp_head", 32'(KEY_CODE), 32'(8'h22));
    idle(5, 1'b1);
    chk("fullpp_empty", 32'(EVENT_VALID), 0);

    // Timeout: gap of TMO-1 keeps the prefix, gap of TMO drops it
    cycle(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    idle(TMO - 1, 1'b0);
    cycle(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("tmo_short_ext", 32'(KEY_EXTENDED), 1);
    idle(1, 1'b1);
    cycle(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    idle(TMO, 1'b0);
    cycle(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("tmo_code", 32'(KEY_CODE), 32'(8'h1C));
    chk("tmo_ext", 32'(KEY_EXTENDED), 0);
    idle(1, 1'b1);

    // Reset mid-sequence discards the F0 prefix and the error count
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("midrst_err", 32'(PARITY_ERR_CNT), 0);
    cycle(1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("midrst_code", 32'(KEY_CODE), 32'(8'h1C));
    chk("midrst_rel", 32'(KEY_RELEASED), 0);

    // Random traffic against the model
    for (int seg = 0; seg < 15; seg++) begin
      int pv, pr;
      pv = (seg % 3 == 0) ? 50 : ((seg % 3 == 1) ? 15 : 3);
      pr = (seg % 2 == 0) ? 70 : 20;
      for (int i = 0; i < 200; i++) begin
        logic v, p, r, rs;
        logic [7:0] c;
        int sel;
        sel = int'($urandom_range(0, 9));
        c   = (sel < 3) ? 8'hE0 : ((sel < 5) ? 8'hF0 : 8'($urandom_range(0, 255)));
        v   = ($urandom_range(0, 99) < pv);
        p   = ($urandom_range(0, 19) != 0);
        r   = ($urandom_range(0, 99) < pr);
        rs  = ($urandom_range(0, 499) == 0);
        cycle(v, c, p, r, rs);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scan_code_decoder.md
PS2_SCAN_CODE_DECODER -- requirements
Module: ps2_scan_code_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 2500000, FCLK cycles a prefix state waits for the next byte before abandoning.
REQ-003 FCLK  input  1  single fast system clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 SCAN_CODE  input  8  received byte from the upstream PS/2 receive stage.
REQ-006 CODE_VALID  input  1  one-FCLK strobe: SCAN_CODE holds a complete frame.
REQ-007 PARITY_OK  input  1  parity status of that frame, sampled with CODE_VALID.
REQ-008 EVENT_READY  input  1  consumer accepts the current event.
REQ-009 EVENT_VALID  output  1  FIFO non-empty; event fields valid.
REQ-010 KEY_CODE  output  8  make/break code without prefixes.
REQ-011 KEY_EXTENDED  output  1  event carried an E0 prefix.
REQ-012 KEY_RELEASED  output  1  event carried an F0 prefix (break).
REQ-013 OVERFLOW  output  1  sticky: an event was dropped on a full FIFO.
REQ-014 PARITY_ERR_CNT  output  8  saturating count of rejected frames.

Function
REQ-015 Input byte accepted only on FCLK edges where CODE_VALID=1; CODE_VALID held >1 cycle counts once per cycle.
REQ-016 CODE_VALID=1 with PARITY_OK=0: byte discarded, FSM to IDLE, PARITY_ERR_CNT +1, saturate at 8'hFF.
REQ-017 FSM states IDLE, EXT, BRK, EXT_BRK.
REQ-018 IDLE: E0 -> EXT; F0 -> BRK; other byte -> emit {ext=0,rel=0}, stay IDLE.
REQ-019 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit {ext=1,rel=0}, IDLE.
REQ-020 BRK: E0 or F0 -> IDLE, no emit; other -> emit {ext=0,rel=1}, IDLE.
REQ-021 EXT_BRK: E0 or F0 -> IDLE, no emit; other -> emit {ext=1,rel=1}, IDLE.
REQ-022 Timeout counter clears on every accepted byte, counts only in non-IDLE states; reaching TIMEOUT_CYCLES forces IDLE, no emit.
REQ-023 Emit writes 10-bit entry {ext,rel,code} to FIFO in the cycle after the accepting edge; EVENT_VALID rises one cycle after the CODE_VALID edge when FIFO was empty.
REQ-024 FIFO show-ahead: KEY_* reflect the head entry whenever EVENT_VALID=1; pop on EVENT_VALID && EVENT_READY.
REQ-025 Write pointer and read pointer wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-026 Push while full and no pop: entry dropped, FIFO unchanged, OVERFLOW set until RST.
REQ-027 Push and pop same cycle while full: both take effect, no overflow; while empty: entry must not bypass (appears next cycle).
REQ-028 EVENT_READY while EVENT_VALID=0: no effect.

Reset
REQ-029 RST=1 on an FCLK edge: FSM IDLE, timeout counter 0, FIFO pointers and count 0, OVERFLOW 0, PARITY_ERR_CNT 0.
REQ-030 Outputs during/after reset: EVENT_VALID 0, KEY_CODE 8'h00, KEY_EXTENDED 0, KEY_RELEASED 0.
REQ-031 RST asserted mid-sequence (e.g. after E0) discards the partial prefix and all queued events; RST dominates CODE_VALID in the same cycle.

Structure
REQ-032 Shared package/header ps2_defs holds PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BRK = 8'hF0, FSM state encodings and the event entry width (10).
REQ-033 FIFO implemented as sub-module ps2_event_fifo (parameter DEPTH, WIDTH=10, push/pop/full/empty); FSM, timeout and error counter in the top.
REQ-034 No combinational path from CODE_VALID or SCAN_CODE to any output.

Verification
REQ-035 Bytes 1C (parity ok) -> one event KEY_CODE=1C, ext=0, rel=0, EVENT_VALID one cycle after strobe.
REQ-036 Bytes E0,F0,74 with EVENT_READY=0 -> single event 74, ext=1, rel=1; no events for prefixes.
REQ-037 Five make codes 15,16,17,18,19 with EVENT_READY=0, FIFO_DEPTH=4 -> events 15..18 retained, OVERFLOW=1; then READY=1 -> pops 15,16,17,18 in order.
REQ-038 Byte F0 with PARITY_OK=0 then 1C -> PARITY_ERR_CNT=1, event 1C with rel=0.
REQ-039 E0 then idle TIMEOUT_CYCLES (bench override 16) then 1C -> event 1C with ext=0.
REQ-040 F0 then RST one cycle then 1C -> event 1C, rel=0; all counters and OVERFLOW zero after RST.
